// File: rtl/ps2_frame_receiver.sv
// Device-to-host PS/2 frame receiver: synchronises and deglitches the PS/2 clock,
// shifts in 11-bit frames and reports each frame as exactly one strobe.
module ps2_frame_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       qzt_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_en,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Data bits plus the parity bit must XOR to 1 for odd parity.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

  logic            clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
  logic            filt_clk_r;
  logic [7:0]      filt_cnt_r;
  logic            fall_s;
  state_t          state_r;
  logic [3:0]      bit_cnt_r;
  logic [TO_W-1:0] to_cnt_r;
  logic [9:0]      shift_r;
  logic [7:0]      rx_byte_r;
  logic            rx_valid_r, parity_err_r, frame_err_r, busy_r;

  // Two-stage synchronisers for the asynchronous bus lines.
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // Glitch filter: the filtered clock flips only after FILTER_LEN disagreeing samples in a row.
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      filt_clk_r <= 1'b1;
      filt_cnt_r <= 8'd0;
    end else if (clk_sync_r != filt_clk_r) begin
      if (filt_cnt_r == 8'(FILTER_LEN - 1)) begin
        filt_clk_r <= clk_sync_r;
        filt_cnt_r <= 8'd0;
      end else begin
        filt_cnt_r <= filt_cnt_r + 8'd1;
      end
    end else begin
      filt_cnt_r <= 8'd0;
    end
  end

  // The FSM acts on the same edge that drives the filtered clock low.
  assign fall_s = filt_clk_r & ~clk_sync_r & (filt_cnt_r == 8'(FILTER_LEN - 1));

  // Frame FSM with registered strobes; rx_en low forces idle and drops any pending strobe.
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 4'd0;
      to_cnt_r     <= '0;
      shift_r      <= 10'd0;
      rx_byte_r    <= 8'h00;
      rx_valid_r   <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      rx_valid_r   <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      if (!rx_en) begin
        state_r   <= ST_IDLE;
        bit_cnt_r <= 4'd0;
        to_cnt_r  <= '0;
        busy_r    <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            to_cnt_r <= '0;
            if (fall_s) begin
              if (!data_sync_r) begin
                state_r   <= ST_SHIFT;
                bit_cnt_r <= 4'd1;
                busy_r    <= 1'b1;
              end else begin
                frame_err_r <= 1'b1;
              end
            end
          end
          ST_SHIFT: begin
            if (fall_s) begin
              shift_r   <= {data_sync_r, shift_r[9:1]};
              bit_cnt_r <= bit_cnt_r + 4'd1;
              to_cnt_r  <= '0;
              if (bit_cnt_r == 4'd10) begin
                state_r <= ST_DONE;
                busy_r  <= 1'b0;
              end
            end else if (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
              frame_err_r <= 1'b1;
              state_r     <= ST_IDLE;
              bit_cnt_r   <= 4'd0;
              to_cnt_r    <= '0;
              busy_r      <= 1'b0;
            end else begin
              to_cnt_r <= to_cnt_r + TO_W'(1);
            end
          end
          ST_DONE: begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            to_cnt_r  <= '0;
            // A bad stop bit outranks a parity fault so each frame yields one strobe.
            if (!shift_r[9]) begin
              frame_err_r <= 1'b1;
            end else if (!odd_parity_ok(shift_r[8:0])) begin
              parity_err_r <= 1'b1;
            end else begin
              rx_byte_r  <= shift_r[7:0];
              rx_valid_r <= 1'b1;
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            to_cnt_r  <= '0;
            busy_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_byte    = rx_byte_r;
  assign rx_valid   = rx_valid_r;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;
  assign busy       = busy_r;

endmodule
